// File: rtl/store_pkg.sv
// Shared definitions for the store-data formatter: access-size encodings,
// output/skid buffer states and byte-enable helpers.
package store_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } storeSize_e;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_TWO   = 2'b10
  } bufState_e;

  localparam logic [3:0] BE_FULL = 4'b1111;

  // Halfword lanes: upper half when address bit 1 is set, lower half otherwise.
  function automatic logic [3:0] halfBe(input logic addrBit1);
    halfBe = addrBit1 ? 4'b1100 : 4'b0011;
  endfunction

endpackage

// File: rtl/store_lane_align.sv
// Combinational lane placement for a store: replicates the operand across
// the byte lanes, builds byte enables from the low address bits and flags
// accesses whose low address bits do not suit the access size.
module store_lane_align
  import store_pkg::*;
(
  input  logic [1:0]  lane,
  input  logic [1:0]  size,
  input  logic [31:0] data,
  output logic [31:0] wdata,
  output logic [3:0]  be,
  output logic        misaligned
);

  // Size decode: reserved size is formatted like a word but always flagged.
  always_comb begin
    wdata      = data;
    be         = BE_FULL;
    misaligned = 1'b0;
    case (size)
      SZ_BYTE: begin
        wdata      = {4{data[7:0]}};
        be         = 4'b0001 << lane;
        misaligned = 1'b0;
      end
      SZ_HALF: begin
        wdata      = {2{data[15:0]}};
        be         = halfBe(lane[1]);
        misaligned = lane[0];
      end
      SZ_WORD: begin
        wdata      = data;
        be         = BE_FULL;
        misaligned = (lane != 2'b00);
      end
      default: begin
        wdata      = data;
        be         = BE_FULL;
        misaligned = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/store_narrow.sv
// Store-data formatter for the MEM stage. Narrows a register operand into a
// word-aligned, lane-replicated memory write with byte enables and queues it
// in a two-entry output/skid buffer so one store per cycle is sustained under
// memory backpressure. in_ready depends only on the registered buffer state.
// Optional build macro: STORE_ALIGN_CHECK_EN (misaligned/reserved stores are
// accepted but dropped, and raise a one-cycle fault with the address).
module store_narrow
  import store_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [31:0]       in_data,
  input  logic [1:0]        in_size,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_be,
  output logic              fault,
  output logic [ADDR_W-1:0] fault_addr
);

`ifdef STORE_ALIGN_CHECK_EN
  localparam logic ALIGN_CHECK = 1'b1;
`else
  localparam logic ALIGN_CHECK = 1'b0;
`endif

  bufState_e         state_r;
  bufState_e         nextState_s;
  logic              inReady_s;
  logic              memValid_s;
  logic              accept_s;
  logic              enq_s;
  logic              drain_s;
  logic [ADDR_W-1:0] newAddr_s;
  logic [31:0]       newData_s;
  logic [3:0]        newBe_s;
  logic              misaligned_s;
  logic [ADDR_W-1:0] outAddr_r;
  logic [31:0]       outData_r;
  logic [3:0]        outBe_r;
  logic [ADDR_W-1:0] skidAddr_r;
  logic [31:0]       skidData_r;
  logic [3:0]        skidBe_r;

  store_lane_align uAlign (
    .lane       (in_addr[1:0]),
    .size       (in_size),
    .data       (in_data),
    .wdata      (newData_s),
    .be         (newBe_s),
    .misaligned (misaligned_s)
  );

  assign newAddr_s = {in_addr[ADDR_W-1:2], 2'b00};
  assign accept_s  = in_valid & inReady_s;
  assign enq_s     = accept_s & ~(ALIGN_CHECK & misaligned_s);
  assign drain_s   = memValid_s & mem_ready;

  // Buffer state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_EMPTY;
    end else begin
      state_r <= nextState_s;
    end
  end

  // Buffer occupancy transitions from enqueue/drain events.
  always_comb begin
    nextState_s = state_r;
    case (state_r)
      ST_EMPTY: begin
        if (enq_s) nextState_s = ST_ONE;
        else       nextState_s = ST_EMPTY;
      end
      ST_ONE: begin
        if (enq_s && !drain_s)      nextState_s = ST_TWO;
        else if (!enq_s && drain_s) nextState_s = ST_EMPTY;
        else                        nextState_s = ST_ONE;
      end
      ST_TWO: begin
        if (drain_s) nextState_s = ST_ONE;
        else         nextState_s = ST_TWO;
      end
      default: nextState_s = ST_EMPTY;
    endcase
  end

  // Handshake outputs decoded from the registered state only.
  always_comb begin
    inReady_s  = 1'b1;
    memValid_s = 1'b0;
    case (state_r)
      ST_EMPTY: begin
        inReady_s  = 1'b1;
        memValid_s = 1'b0;
      end
      ST_ONE: begin
        inReady_s  = 1'b1;
        memValid_s = 1'b1;
      end
      ST_TWO: begin
        inReady_s  = 1'b0;
        memValid_s = 1'b1;
      end
      default: begin
        inReady_s  = 1'b1;
        memValid_s = 1'b0;
      end
    endcase
  end

  // Output and skid registers: out reg is the head, skid holds the second entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outAddr_r  <= '0;
      outData_r  <= 32'h0000_0000;
      outBe_r    <= 4'b0000;
      skidAddr_r <= '0;
      skidData_r <= 32'h0000_0000;
      skidBe_r   <= 4'b0000;
    end else begin
      case (state_r)
        ST_EMPTY: begin
          if (enq_s) begin
            outAddr_r <= newAddr_s;
            outData_r <= newData_s;
            outBe_r   <= newBe_s;
          end
        end
        ST_ONE: begin
          if (enq_s && drain_s) begin
            outAddr_r <= newAddr_s;
            outData_r <= newData_s;
            outBe_r   <= newBe_s;
          end else if (enq_s) begin
            skidAddr_r <= newAddr_s;
            skidData_r <= newData_s;
            skidBe_r   <= newBe_s;
          end
        end
        ST_TWO: begin
          if (drain_s) begin
            outAddr_r <= skidAddr_r;
            outData_r <= skidData_r;
            outBe_r   <= skidBe_r;
          end
        end
        default: begin
          outAddr_r <= outAddr_r;
        end
      endcase
    end
  end

  assign in_ready  = inReady_s;
  assign mem_valid = memValid_s;
  assign mem_addr  = outAddr_r;
  assign mem_wdata = outData_r;
  assign mem_be    = outBe_r;

`ifdef STORE_ALIGN_CHECK_EN
  logic              fault_r;
  logic [ADDR_W-1:0] faultAddr_r;

  // One-cycle fault pulse and sticky fault address for dropped stores.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fault_r     <= 1'b0;
      faultAddr_r <= '0;
    end else begin
      fault_r <= accept_s & misaligned_s;
      if (accept_s && misaligned_s) begin
        faultAddr_r <= in_addr;
      end
    end
  end

  assign fault      = fault_r;
  assign fault_addr = faultAddr_r;
`else
  assign fault      = 1'b0;
  assign fault_addr = '0;
`endif

endmodule

// File: tb/tb_store_narrow.sv
// Directed self-checking bench for store_narrow. Inputs change and outputs
// are sampled 1ns after the rising edge.
module tb_store_narrow;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_addr;
  logic [31:0] in_data;
  logic [1:0]  in_size;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        fault;
  logic [31:0] fault_addr;

  int tests;
  int fails;

  store_narrow #(.ADDR_W(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_addr    (in_addr),
    .in_data    (in_data),
    .in_size    (in_size),
    .mem_valid  (mem_valid),
    .mem_ready  (mem_ready),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_be     (mem_be),
    .fault      (fault),
    .fault_addr (fault_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
    in_valid = v;
    in_addr  = a;
    in_data  = d;
    in_size  = s;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    mem_ready = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 2'b00);
    tick();
    tick();
    tests++; if (mem_valid !== 1'b0) begin fails++; $display("FAIL reset_mem_valid got %b exp 0", mem_valid); end
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    tests++; if ({mem_addr, mem_wdata, mem_be} !== 68'h0) begin fails++; $display("FAIL reset_data got %h %h %b exp 0", mem_addr, mem_wdata, mem_be); end
    tests++; if ({fault, fault_addr} !== 33'h0) begin fails++; $display("FAIL reset_fault got %b %h exp 0", fault, fault_addr); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_byte();
    mem_ready = 1'b1;
    drive(1'b1, 32'h0000_1003, 32'h0000_00A5, 2'b00);
    tick();
    tests++; if ({mem_valid, mem_addr} !== {1'b1, 32'h0000_1000}) begin fails++; $display("FAIL sb_addr got %b %h exp 1 00001000", mem_valid, mem_addr); end
    tests++; if (mem_wdata !== 32'hA5A5_A5A5) begin fails++; $display("FAIL sb_wdata got %h exp a5a5a5a5", mem_wdata); end
    tests++; if (mem_be !== 4'b1000) begin fails++; $display("FAIL sb_be got %b exp 1000", mem_be); end
    drive(1'b1, 32'h0000_1001, 32'h1234_5677, 2'b00);
    tick();
    tests++; if ({mem_valid, mem_be, mem_wdata} !== {1'b1, 4'b0010, 32'h7777_7777}) begin fails++; $display("FAIL sb_lane1 got %b %b %h exp 1 0010 77777777", mem_valid, mem_be, mem_wdata); end
    drive(1'b0, 32'h0, 32'h0, 2'b00);
    tick();
    tests++; if (mem_valid !== 1'b0) begin fails++; $display("FAIL sb_drain got %b exp 0", mem_valid); end
  endtask

  task automatic test_half_word();
    mem_ready = 1'b1;
    drive(1'b1, 32'h0000_2002, 32'h1234_BEEF, 2'b01);
    tick();
    tests++; if ({mem_valid, mem_addr, mem_wdata, mem_be} !== {1'b1, 32'h0000_2000, 32'hBEEF_BEEF, 4'b1100}) begin fails++; $display("FAIL sh_hi got %b %h %h %b exp 1 00002000 beefbeef 1100", mem_valid, mem_addr, mem_wdata, mem_be); end
    drive(1'b1, 32'h0000_2000, 32'h5555_0A0B, 2'b01);
    tick();
    tests++; if ({mem_wdata, mem_be} !== {32'h0A0B_0A0B, 4'b0011}) begin fails++; $display("FAIL sh_lo got %h %b exp 0a0b0a0b 0011", mem_wdata, mem_be); end
    drive(1'b1, 32'h0000_3000, 32'hDEAD_BEEF, 2'b10);
    tick();
    tests++; if ({mem_valid, mem_addr, mem_wdata, mem_be} !== {1'b1, 32'h0000_3000, 32'hDEAD_BEEF, 4'b1111}) begin fails++; $display("FAIL sw got %b %h %h %b exp 1 00003000 deadbeef 1111", mem_valid, mem_addr, mem_wdata, mem_be); end
    drive(1'b0, 32'h0, 32'h0, 2'b00);
    tick();
  endtask

  task automatic test_back_to_back();
    mem_ready = 1'b0;
    drive(1'b1, 32'h0000_5000, 32'h1111_1111, 2'b10);
    tick();
    drive(1'b1, 32'h0000_5004, 32'h2222_2222, 2'b10);
    tick();
    drive(1'b1, 32'h0000_5008, 32'h3333_3333, 2'b10);
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL b2b_full_ready got %b exp 0", in_ready); end
    tick();
    tick();
    tests++; if ({mem_valid, mem_addr, mem_wdata, in_ready} !== {1'b1, 32'h0000_5000, 32'h1111_1111, 1'b0}) begin fails++; $display("FAIL b2b_stall got %b %h %h %b exp 1 00005000 11111111 0", mem_valid, mem_addr, mem_wdata, in_ready); end
    mem_ready = 1'b1;
    tick();
    tests++; if ({mem_valid, mem_addr, mem_wdata, in_ready} !== {1'b1, 32'h0000_5004, 32'h2222_2222, 1'b1}) begin fails++; $display("FAIL b2b_second got %b %h %h %b exp 1 00005004 22222222 1", mem_valid, mem_addr, mem_wdata, in_ready); end
    tick();
    drive(1'b0, 32'h0, 32'h0, 2'b00);
    tests++; if ({mem_valid, mem_addr, mem_wdata} !== {1'b1, 32'h0000_5008, 32'h3333_3333}) begin fails++; $display("FAIL b2b_third got %b %h %h exp 1 00005008 33333333", mem_valid, mem_addr, mem_wdata); end
    tick();
    tests++; if (mem_valid !== 1'b0) begin fails++; $display("FAIL b2b_empty got %b exp 0", mem_valid); end
  endtask

  task automatic test_misaligned();
    mem_ready = 1'b1;
    drive(1'b1, 32'h0000_4001, 32'h0000_CAFE, 2'b01);
    tick();
`ifdef STORE_ALIGN_CHECK_EN
    drive(1'b1, 32'h0000_4004, 32'h0BAD_F00D, 2'b10);
    tests++; if ({mem_valid, fault, fault_addr} !== {1'b0, 1'b1, 32'h0000_4001}) begin fails++; $display("FAIL mis_fault got %b %b %h exp 0 1 00004001", mem_valid, fault, fault_addr); end
    tick();
    drive(1'b0, 32'h0, 32'h0, 2'b00);
    tests++; if ({mem_valid, mem_addr, fault, fault_addr} !== {1'b1, 32'h0000_4004, 1'b0, 32'h0000_4001}) begin fails++; $display("FAIL mis_next got %b %h %b %h exp 1 00004004 0 00004001", mem_valid, mem_addr, fault, fault_addr); end
`else
    drive(1'b0, 32'h0, 32'h0, 2'b00);
    tests++; if ({mem_valid, mem_addr, mem_wdata, mem_be, fault} !== {1'b1, 32'h0000_4000, 32'hCAFE_CAFE, 4'b0011, 1'b0}) begin fails++; $display("FAIL mis_nocheck got %b %h %h %b %b exp 1 00004000 cafecafe 0011 0", mem_valid, mem_addr, mem_wdata, mem_be, fault); end
    tick();
    tests++; if ({mem_valid, fault, fault_addr} !== {1'b0, 1'b0, 32'h0}) begin fails++; $display("FAIL mis_nocheck_after got %b %b %h exp 0 0 0", mem_valid, fault, fault_addr); end
`endif
    tick();
  endtask

  task automatic test_reset_mid();
    mem_ready = 1'b0;
    drive(1'b1, 32'h0000_6000, 32'hAAAA_AAAA, 2'b10);
    tick();
    drive(1'b1, 32'h0000_6004, 32'hBBBB_BBBB, 2'b10);
    tick();
    drive(1'b0, 32'h0, 32'h0, 2'b00);
    tests++; if ({mem_valid, in_ready} !== 2'b10) begin fails++; $display("FAIL rst_mid_full got %b %b exp 1 0", mem_valid, in_ready); end
    #2;
    rst_n = 1'b0;
    #1;
    tests++; if ({mem_valid, in_ready} !== 2'b01) begin fails++; $display("FAIL rst_mid_async got %b %b exp 0 1", mem_valid, in_ready); end
    mem_ready = 1'b1;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      tests++; if (mem_valid !== 1'b0) begin fails++; $display("FAIL rst_mid_quiet cycle %0d got %b exp 0", i, mem_valid); end
    end
    drive(1'b1, 32'h0000_7002, 32'h0000_00C3, 2'b00);
    tick();
    drive(1'b0, 32'h0, 32'h0, 2'b00);
    tests++; if ({mem_valid, mem_addr, mem_wdata, mem_be} !== {1'b1, 32'h0000_7000, 32'hC3C3_C3C3, 4'b0100}) begin fails++; $display("FAIL rst_mid_new got %b %h %h %b exp 1 00007000 c3c3c3c3 0100", mem_valid, mem_addr, mem_wdata, mem_be); end
    tick();
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_byte();
    test_half_word();
    test_back_to_back();
    test_misaligned();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/store_narrow.md
# store_narrow

Store-data formatter in the MEM stage of the pipelined MIPS core; the write-direction counterpart of immediate/load sign extension. Takes a 32-bit register operand plus byte address and access size (sb/sh/sw), narrows it into a word-aligned data-memory write with replicated lanes and byte enables, and buffers it behind a valid/ready handshake. A two-entry output/skid buffer sustains one store per cycle under memory backpressure.

## Interface
- ADDR_W, 32, byte-address width on both sides
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  store request valid
- in_ready  out  1  block can accept; transfer on in_valid & in_ready
- in_addr  in  ADDR_W  byte address
- in_data  in  32  register operand (rt)
- in_size  in  2  00 byte, 01 half, 10 word, 11 reserved
- mem_valid  out  1  memory write valid
- mem_ready  in  1  memory accepts; transfer on mem_valid & mem_ready
- mem_addr  out  ADDR_W  word address, bits [1:0] always 0
- mem_wdata  out  32  lane-replicated write data
- mem_be  out  4  byte enables, bit i = bits [8i+7:8i]
- fault  out  1  one-cycle misalignment pulse (STORE_ALIGN_CHECK_EN only, else tied 0)
- fault_addr  out  ADDR_W  address of most recent faulting store

## Operation
- Little-endian lane mapping, lane = in_addr[1:0].
- Byte: wdata = {4{in_data[7:0]}}, be = 4'b0001 << addr[1:0].
- Half: wdata = {2{in_data[15:0]}}, be = addr[1] ? 1100 : 0011.
- Word: wdata = in_data, be = 1111.
- mem_addr = {in_addr[ADDR_W-1:2], 2'b00}.
- Buffer states: EMPTY (out reg empty), ONE (out reg full), TWO (out reg + skid full).
  - EMPTY: accept -> ONE.
  - ONE: accept & !drain -> TWO; drain & !accept -> EMPTY; accept & drain -> ONE (out reg loads new entry).
  - TWO: in_ready=0; drain -> ONE, skid moves to out reg.
- in_ready = state != TWO (registered-state decode, no combinational path from mem_ready).
- Strict FIFO order; no store dropped or duplicated except faults.

## Timing
- Latency: accepted at edge N -> mem_valid/addr/wdata/be valid after edge N (cycle N+1) when buffer was EMPTY or draining.
- mem_valid, mem_addr, mem_wdata, mem_be stable while mem_valid & !mem_ready.
- Throughput 1 store/cycle while mem_ready=1.
- Reset values: mem_valid 0, mem_addr 0, mem_wdata 0, mem_be 0, fault 0, fault_addr 0, state EMPTY, in_ready 1.
- Reset asserted mid-operation: all buffered entries discarded immediately, no memory write issued after rst_n falls.
- fault asserted the cycle after the faulting handshake, for exactly one cycle; fault_addr updated same edge, held until next fault.

## Configuration
- STORE_ALIGN_CHECK_EN defined: half with addr[0]=1, word with addr[1:0]!=0, or size 11 is accepted (handshake completes) but not enqueued; fault pulses, fault_addr captures in_addr.
- Undefined: no checking; misaligned low bits ignored (half uses addr[1], word ignores addr[1:0]); size 11 treated as word; fault and fault_addr tied 0.

## Structure
- Shared package store_pkg: size encodings SZ_BYTE/SZ_HALF/SZ_WORD/SZ_RSVD, buffer state enum, BE_FULL constant.
- Sub-module store_lane_align: combinational addr/size/data -> wdata, be, misaligned flag; instanced once ahead of the buffer.

## Test plan
- sb addr 0x1003 data 0x000000A5, mem_ready=1 -> next cycle mem_addr 0x1000, wdata 0xA5A5A5A5, be 1000.
- sh addr 0x2002 data 0x1234BEEF -> mem_addr 0x2000, wdata 0xBEEFBEEF, be 1100; sw 0x3000 0xDEADBEEF -> be 1111, data unchanged.
- mem_ready=0 for 4 cycles, three back-to-back sw -> two accepted, in_ready 0 on third; release -> writes emerge in order, third accepted, none lost.
- With STORE_ALIGN_CHECK_EN: sh addr 0x4001 -> no mem_valid, fault pulse 1 cycle, fault_addr 0x4001; following sw 0x4004 issues normally.
- Without macro: same sh 0x4001 -> mem_addr 0x4000, be 0011, fault stays 0.
- rst_n low with buffer in TWO -> mem_valid 0 immediately, in_ready 1, no writes after release until new input.
